// File: rtl/l1_rd_ctrl_multi.sv
// Multi-port L1 read-address controller. It ranks same-stream requests by port index and
// gates grants by stream occupancy. It owns the per-stream read pointers and reports consumption.
module l1_rd_ctrl_multi #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int nports    = 8,
  parameter int ptr_width = 4,
  parameter int cnt_width = ptr_width + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nports-1:0]              i_rd_v,
  output logic [nports-1:0]              i_rd_r,
  input  logic [nports*sid_width-1:0]    i_rd_sid,
  input  logic [nstrms*cnt_width-1:0]    i_cnt,
  input  logic                           i_flush_v,
  input  logic [sid_width-1:0]           i_flush_sid,
  output logic [nports-1:0]              o_addr_v,
  input  logic [nports-1:0]              o_addr_r,
  output logic [nports*ptr_width-1:0]    o_addr_ptr,
  output logic [nports*sid_width-1:0]    o_addr_sid,
  output logic [nstrms-1:0]              o_adv_v,
  output logic [nstrms*cnt_width-1:0]    o_adv_cnt
);
  localparam logic [cnt_width-1:0] C_ONE = cnt_width'(1'b1);

  logic [nports-1:0]    r_s1_v;
  logic [sid_width-1:0] r_s1_sid   [nports];
  logic [nports-1:0]    r_addr_v;
  logic [ptr_width-1:0] r_addr_ptr [nports];
  logic [sid_width-1:0] r_addr_sid [nports];
  logic [ptr_width-1:0] r_rd_ptr   [nstrms];

  logic [cnt_width-1:0] w_cnt  [nstrms];
  logic [cnt_width-1:0] w_n    [nstrms];
  logic [cnt_width-1:0] w_rank [nports];
  logic [nports-1:0]    w_elig;
  logic [nports-1:0]    w_grant;

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      w_cnt[s] = i_cnt[s*cnt_width +: cnt_width];
    end
  end

  // A port stalled on its output register is not eligible and takes no rank.
  always_comb begin
    for (int p = 0; p < nports; p++) begin
      w_elig[p] = r_s1_v[p] & (~r_addr_v[p] | o_addr_r[p]);
    end
  end

  always_comb begin
    for (int p = 0; p < nports; p++) begin
      w_rank[p] = '0;
      for (int q = 0; q < p; q++) begin
        if (w_elig[q] && (r_s1_sid[q] == r_s1_sid[p])) begin
          w_rank[p] = w_rank[p] + C_ONE;
        end else begin
          w_rank[p] = w_rank[p];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < nports; p++) begin
      w_grant[p] = w_elig[p] & (w_rank[p] < w_cnt[r_s1_sid[p]])
                   & ~(i_flush_v & (i_flush_sid == r_s1_sid[p]));
    end
  end

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      w_n[s] = '0;
    end
    for (int p = 0; p < nports; p++) begin
      if (w_grant[p]) begin
        w_n[r_s1_sid[p]] = w_n[r_s1_sid[p]] + C_ONE;
      end else begin
        w_n[r_s1_sid[p]] = w_n[r_s1_sid[p]];
      end
    end
  end

  always_comb begin
    i_rd_r     = '0;
    o_adv_v    = '0;
    o_adv_cnt  = '0;
    o_addr_ptr = '0;
    o_addr_sid = '0;
    for (int p = 0; p < nports; p++) begin
      i_rd_r[p]                            = ~reset & (~r_s1_v[p] | w_grant[p]);
      o_addr_ptr[p*ptr_width +: ptr_width] = r_addr_ptr[p];
      o_addr_sid[p*sid_width +: sid_width] = r_addr_sid[p];
    end
    for (int s = 0; s < nstrms; s++) begin
      o_adv_v[s]                           = ~reset & (w_n[s] != '0);
      o_adv_cnt[s*cnt_width +: cnt_width]  = reset ? '0 : w_n[s];
    end
  end

  assign o_addr_v = r_addr_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v <= '0;
      for (int p = 0; p < nports; p++) begin
        r_s1_sid[p] <= '0;
      end
    end else begin
      for (int p = 0; p < nports; p++) begin
        if (i_rd_v[p] && i_rd_r[p]) begin
          r_s1_v[p]   <= 1'b1;
          r_s1_sid[p] <= i_rd_sid[p*sid_width +: sid_width];
        end else if (w_grant[p]) begin
          r_s1_v[p]   <= 1'b0;
        end
      end
    end
  end

  // Each granted port gets the stream pointer offset by its rank among same-stream grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_v <= '0;
      for (int p = 0; p < nports; p++) begin
        r_addr_ptr[p] <= '0;
        r_addr_sid[p] <= '0;
      end
    end else begin
      for (int p = 0; p < nports; p++) begin
        if (w_grant[p]) begin
          r_addr_v[p]   <= 1'b1;
          r_addr_ptr[p] <= r_rd_ptr[r_s1_sid[p]] + w_rank[p][ptr_width-1:0];
          r_addr_sid[p] <= r_s1_sid[p];
        end else if (o_addr_r[p]) begin
          r_addr_v[p]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        r_rd_ptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < nstrms; s++) begin
        if (i_flush_v && (i_flush_sid == sid_width'(s))) begin
          r_rd_ptr[s] <= '0;
        end else begin
          r_rd_ptr[s] <= r_rd_ptr[s] + w_n[s][ptr_width-1:0];
        end
      end
    end
  end
endmodule

// File: doc/l1_rd_ctrl_multi.md
Name: l1_rd_ctrl_multi

Overview:
- Multi-port L1 read-address controller. It serves all `nports` read ports of the multi-stream buffer in one block.
- It owns the per-stream read pointers and arbitrates same-stream requests across ports by port-index rank.
- Grants are gated by per-stream occupancy. Pointers advance modulo the stream depth.
- It emits registered BRAM addresses per port, plus per-stream consumption pulses to the L1 occupancy tracker.

Parameters:
- nstrms, 64, number of streams.
- sid_width, $clog2(nstrms), stream id width.
- nports, 8, number of read ports.
- ptr_width, 4, per-stream pointer width; stream depth = 2^ptr_width.
- cnt_width, ptr_width+1, occupancy/consume count width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_rd_v  input  nports  per-port read request valid.
- i_rd_r  output  nports  per-port request ready.
- i_rd_sid  input  nports*sid_width  per-port requested stream id.
- i_cnt  input  nstrms*cnt_width  per-stream occupancy (entries readable).
- i_flush_v  input  1  flush one stream's pointer.
- i_flush_sid  input  sid_width  stream to flush.
- o_addr_v  output  nports  per-port address valid.
- o_addr_r  input  nports  per-port address ready.
- o_addr_ptr  output  nports*ptr_width  per-port pointer within the stream.
- o_addr_sid  output  nports*sid_width  per-port stream id.
- o_adv_v  output  nstrms  stream consumed ≥1 entry this cycle (combinational).
- o_adv_cnt  output  nstrms*cnt_width  entries consumed per stream this cycle (combinational).

Behaviour:
- Reset (async): all rd_ptr[s]=0, s1 valids=0, o_addr_v=0, o_addr_ptr/sid=0.
- During reset: i_rd_r=0 and o_adv_v=0.
- Stage s1, per port: input register. It loads when i_rd_v[p] & i_rd_r[p].
  - i_rd_r[p] = ~s1_v[p] | grant[p].
- Eligibility: elig[p] = s1_v[p] & (~o_addr_v[p] | o_addr_r[p]).
- Rank: rank[p] = number of q<p with elig[q] and s1_sid[q]==s1_sid[p].
  - Width $clog2(nports+1), zero-extended to cnt_width for comparison.
- Grant: grant[p] = elig[p] & (rank[p] < i_cnt[s1_sid[p]]) & ~(i_flush_v & i_flush_sid==s1_sid[p]).
  - Grants for one stream are always the lowest-index eligible ports.
  - A non-granted request holds in s1. It re-evaluates every cycle with no starvation reordering.
- Address: on a grant, o_addr_ptr[p] is loaded with (rd_ptr[sid] + rank[p]) mod 2^ptr_width, o_addr_sid[p] with sid, and o_addr_v[p] is set.
  - o_addr_v[p] clears when o_addr_r[p] is high and there is no new grant.
- Latency: request accepted at edge t; address valid at edge t+1 at the earliest.
  - Full throughput is one request per port per cycle.
- Pointer update at each edge: rd_ptr[s] += n_s mod 2^ptr_width, where n_s = number of grants for stream s.
- Consumption outputs: o_adv_cnt[s] = n_s and o_adv_v[s] = (n_s != 0), in the same cycle as the grants.
  - The tracker must subtract them at the same edge, so i_cnt always reflects all prior consumption.
- Flush: when i_flush_v is high, rd_ptr[i_flush_sid] := 0 and no grants occur for that stream this cycle.
  - Flush has priority over any concurrent advance.
  - Addresses already in output registers are unaffected.
- Occupancy i_cnt > nports: clamp is implicit, since at most nports grants per stream per cycle.
- i_cnt=0: no grants for that stream.
- Simultaneous output stall: a stalled port is not eligible. It does not consume a rank, so later ports for the same stream take the lower pointer.
- X-safety: s1_sid is don't-care when s1_v=0. It must not affect rank, grant or o_adv.

Test Plan:
- Single port, sid 5, i_cnt[5]=3, four back-to-back requests → ptrs 0,1,2 on consecutive cycles with o_adv_cnt[5]=1 each. The fourth stalls (i_rd_r[0]=0) until i_cnt[5]=1, then ptr 3.
- Ports 0–3 all sid 2, rd_ptr[2]=6, i_cnt[2]=2 → ports 0,1 get ptrs 6,7 and o_adv_cnt[2]=2. Ports 2,3 hold. Next cycle with i_cnt[2]=4 they get 8,9.
- Wrap: ptr_width=4, rd_ptr[9]=15, ports 0,1 sid 9, i_cnt=5 → ptrs 15,0; rd_ptr[9]=1 afterwards.
- Output backpressure: o_addr_v[1]=1, o_addr_r[1]=0, ports 0,1,2 sid 3, rd_ptr=0 → port 0 gets ptr 0, port 2 gets ptr 1, port 1 holds; o_adv_cnt[3]=2.
- Flush collision: i_flush_v with sid 4 while ports 0,1 request sid 4 with i_cnt=8, rd_ptr=10 → no grants, rd_ptr[4]=0. Next cycle grants give ptrs 0,1.
- Reset asserted mid-traffic with several o_addr_v high → all o_addr_v, i_rd_r and o_adv_v drop immediately. After release, pointers read 0 on the first grant.
